// File: rtl/seq_div_16by8_pkg.sv
// Shared types and constants for the sequential 16/8 restoring divider.
// Defining DIV_APPROX_EN selects the 12-iteration approximate build.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_t;

   localparam int DIV_DW    = 16;
   localparam int DIV_VW    = 8;
   localparam int DIV_CNT_W = 5;

`ifdef DIV_APPROX_EN
   localparam int DIV_ITER = 12;
`else
   localparam int DIV_ITER = 16;
`endif

   localparam logic [DIV_DW-1:0] DIV_Z_QUOT = 16'hFFFF;

endpackage

// File: rtl/seq_div_16by8_if.sv
// Operand/result handshake bundle for seq_div_16by8.
// master drives operands and result acceptance, slave is the divider.
interface seq_div_16by8_if
   import div_pkg::*;
#(
   parameter int DW = DIV_DW,
   parameter int VW = DIV_VW
);

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] a;
   logic [VW-1:0] b;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quot;
   logic [VW-1:0] rem;
   logic          div_by_zero;

   modport master (
      output in_valid,
      output a,
      output b,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  quot,
      input  rem,
      input  div_by_zero
   );

   modport slave (
      input  in_valid,
      input  a,
      input  b,
      input  out_ready,
      output in_ready,
      output out_valid,
      output quot,
      output rem,
      output div_by_zero
   );

endinterface

// File: rtl/seq_div_16by8_step.sv
// One combinational restoring-division iteration: shift in the next
// dividend bit, subtract the divisor if it fits, emit the quotient bit.
module div_step
   import div_pkg::*;
#(
   parameter int VW = DIV_VW
) (
   input  logic [VW:0]   i_r,
   input  logic          i_bit,
   input  logic [VW-1:0] i_b,
   output logic [VW:0]   o_r,
   output logic          o_q
);

   logic [VW:0] w_r9;
   logic [VW:0] w_diff;

   assign w_r9   = {i_r[VW-1:0], i_bit};
   assign w_diff = w_r9 - {1'b0, i_b};

   // A set top bit means the true shifted value exceeds any divisor, so the
   // subtraction must happen; the wrapped 9-bit difference is still exact.
   assign o_q = i_r[VW] | (w_r9 >= {1'b0, i_b});
   assign o_r = o_q ? w_diff : w_r9;

endmodule

// File: rtl/seq_div_16by8.sv
// Sequential 16/8 restoring divider, one quotient bit per clock, with
// valid/ready handshakes on both sides. DIV_APPROX_EN: 12-bit approximate mode.
module seq_div_16by8
   import div_pkg::*;
#(
   parameter int DW = DIV_DW,
   parameter int VW = DIV_VW
) (
   input  logic             clk,
   input  logic             rst,
   seq_div_16by8_if.slave   bus
);

   div_state_t           r_state;
   div_state_t           w_stateNext;

   logic [DW-1:0]        r_aq;
   logic [VW:0]          r_r;
   logic [VW-1:0]        r_b;
   logic [DIV_CNT_W-1:0] r_cnt;

   logic [DW-1:0]        r_quot;
   logic [VW-1:0]        r_rem;
   logic                 r_dbz;
   logic                 r_inReady;

   logic [VW:0]          w_rNext;
   logic                 w_qBit;
   logic [DW-1:0]        w_aqNext;
   logic                 w_accept;
   logic                 w_lastIter;
   logic                 w_bZero;

   assign w_accept   = (r_state == IDLE) && r_inReady && bus.in_valid;
   assign w_lastIter = (r_cnt == DIV_CNT_W'(DIV_ITER - 1));
   assign w_bZero    = (bus.b == '0);
   assign w_aqNext   = {r_aq[DW-2:0], w_qBit};

   div_step #(
      .VW (VW)
   ) u_step (
      .i_r   (r_r),
      .i_bit (r_aq[DW-1]),
      .i_b   (r_b),
      .o_r   (w_rNext),
      .o_q   (w_qBit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_stateNext = w_bZero ? DONE : CALC;
            end
         end
         CALC: begin
            if (w_lastIter) begin
               w_stateNext = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // in_ready follows the next state so it stays low throughout reset and
   // rises on the first edge after release or after the result handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inReady <= 1'b0;
      end else begin
         r_inReady <= (w_stateNext == IDLE);
      end
   end

   // The dividend register doubles as the quotient register: each iteration
   // shifts out a dividend bit at the top and shifts a quotient bit in below.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_aq   <= '0;
         r_r    <= '0;
         r_b    <= '0;
         r_cnt  <= '0;
         r_quot <= '0;
         r_rem  <= '0;
         r_dbz  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_aq  <= bus.a;
                  r_b   <= bus.b;
                  r_r   <= '0;
                  r_cnt <= '0;
                  if (w_bZero) begin
                     r_quot <= DIV_Z_QUOT;
                     r_rem  <= bus.a[VW-1:0];
                     r_dbz  <= 1'b1;
                  end
               end
            end
            CALC: begin
               r_aq  <= w_aqNext;
               r_r   <= w_rNext;
               r_cnt <= r_cnt + 1'b1;
               if (w_lastIter) begin
`ifdef DIV_APPROX_EN
                  r_quot <= {w_aqNext[DIV_ITER-1:0], {(DW - DIV_ITER){1'b0}}};
                  r_rem  <= '0;
`else
                  r_quot <= w_aqNext;
                  r_rem  <= w_rNext[VW-1:0];
`endif
                  r_dbz  <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.in_ready    = r_inReady;
   assign bus.out_valid   = (r_state == DONE);
   assign bus.quot        = r_quot;
   assign bus.rem         = r_rem;
   assign bus.div_by_zero = r_dbz;

endmodule
